// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for an 8-way, 32-bit select mux feeding one valid/ready consumer.
// Ownership is held for a whole multi-beat transfer, with a configurable cap on beats per grant.
module mux_rr_arbiter #(
   parameter int MAX_BEATS = 16,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] req_last,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] grant,
   output logic [2:0] option,
   output logic       busy
);

   localparam logic [0:0]       ST_IDLE = 1'b0;
   localparam logic [0:0]       ST_BUSY = 1'b1;
   localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_BEATS);

   logic [0:0]       state;
   logic [2:0]       last_winner;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [7:0]       owner_oh;
   logic [7:0]       arb_req;
   logic [3:0]       pick;
   logic             accept;
   logic             rel_last;
   logic             rel_cap;
   logic             rel_abandon;
   logic             release_now;

   // Returns {found, index}; scans last_winner+1 .. last_winner+8 so the previous winner is last.
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] lw);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0;
      for (int k = 8; k >= 1; k--) begin
         idx = lw + 3'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign busy      = (state == ST_BUSY);
   assign out_valid = busy & req[option];

   always_comb begin
      owner_oh    = 8'b1 << option;
      cnt_inc     = beat_cnt + CNT_W'(1);
      accept      = out_valid & out_ready;
      rel_last    = accept & req_last[option];
      rel_cap     = accept & (cnt_inc == MAX_C);
      rel_abandon = busy & ~req[option];
      release_now = rel_last | rel_cap | rel_abandon;
      // A capped owner stays eligible; a finished or vanished owner is masked out.
      arb_req     = req & ~(owner_oh & {8{busy & (rel_last | rel_abandon)}});
      pick        = rr_pick(arb_req, last_winner);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         grant       <= 8'h00;
         option      <= 3'd0;
         last_winner <= 3'd7;
         beat_cnt    <= '0;
      end else if (state == ST_IDLE || release_now) begin
         beat_cnt <= '0;
         if (pick[3]) begin
            state       <= ST_BUSY;
            grant       <= 8'b1 << pick[2:0];
            option      <= pick[2:0];
            last_winner <= pick[2:0];
         end else begin
            state <= ST_IDLE;
            grant <= 8'h00;
         end
      end else if (accept) begin
         beat_cnt <= cnt_inc;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (MAX_BEATS=4): a vector table for per-cycle behaviour,
// plus hand-written sequences for stall/abandon and reset during a transfer.
module tb_mux_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] req_last;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] grant;
   logic [2:0] option;
   logic       busy;

   int checks = 0;
   int errors = 0;

   mux_rr_arbiter #(.MAX_BEATS(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_last  (req_last),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .grant     (grant),
      .option    (option),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic [7:0] rq;
      logic [7:0] lst;
      logic       rdy;
      logic [7:0] g;
      logic [2:0] opt;
      logic       b;
      logic       v;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [7:0] rq, input logic [7:0] lst,
                               input logic rdy, input logic [7:0] g, input logic [2:0] opt,
                               input logic b, input logic v);
      vec_t t;
      t.r = r; t.rq = rq; t.lst = lst; t.rdy = rdy;
      t.g = g; t.opt = opt; t.b = b; t.v = v;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Each row: inputs for this cycle, and outputs expected during it (before the next edge).
      vecs.push_back(mk(1, 8'hFF, 8'hFF, 1, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk(0, 8'hFF, 8'hFF, 1, 8'h00, 3'd0, 0, 0));
      for (int k = 0; k < 9; k++)
         vecs.push_back(mk(0, 8'hFF, 8'hFF, 1, 8'b1 << (k % 8), 3'(k % 8), 1, 1));
      vecs.push_back(mk(1, 8'h24, 8'h00, 1, 8'h02, 3'd1, 1, 0));
      vecs.push_back(mk(0, 8'h24, 8'h00, 1, 8'h00, 3'd0, 0, 0));
      vecs.push_back(mk(0, 8'h24, 8'h00, 1, 8'h04, 3'd2, 1, 1));
      vecs.push_back(mk(0, 8'h24, 8'h00, 1, 8'h04, 3'd2, 1, 1));
      vecs.push_back(mk(0, 8'h24, 8'h04, 1, 8'h04, 3'd2, 1, 1));
      vecs.push_back(mk(0, 8'h20, 8'h20, 1, 8'h20, 3'd5, 1, 1));
      vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h00, 3'd5, 0, 0));
      vecs.push_back(mk(1, 8'h00, 8'h00, 1, 8'h00, 3'd5, 0, 0));
      vecs.push_back(mk(0, 8'h48, 8'h00, 1, 8'h00, 3'd0, 0, 0));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(0, 8'h48, 8'h00, 1, 8'h08, 3'd3, 1, 1));
      vecs.push_back(mk(0, 8'h48, 8'h40, 1, 8'h40, 3'd6, 1, 1));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(0, 8'h08, 8'h00, 1, 8'h08, 3'd3, 1, 1));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(0, 8'h48, 8'h00, 1, 8'h08, 3'd3, 1, 1));
      vecs.push_back(mk(0, 8'h40, 8'h40, 1, 8'h40, 3'd6, 1, 1));
      vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h00, 3'd6, 0, 0));

      rst = 1'b1; req = 8'hFF; req_last = 8'hFF; out_ready = 1'b1;
      tick();

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].r; req = vecs[i].rq; req_last = vecs[i].lst; out_ready = vecs[i].rdy;
         #1;
         chk($sformatf("v%0d.grant", i),     grant,     vecs[i].g);
         chk($sformatf("v%0d.option", i),    option,    vecs[i].opt);
         chk($sformatf("v%0d.busy", i),      busy,      vecs[i].b);
         chk($sformatf("v%0d.out_valid", i), out_valid, vecs[i].v);
         tick();
      end

      // Stall then abandon: owner 1 takes one beat, then out_ready=0 for 5 cycles.
      rst = 1'b0; req = 8'h02; req_last = 8'h00; out_ready = 1'b1;
      #1;
      chk("stall.idle_grant", grant, 8'h00);
      tick();
      chk("stall.grant1", grant, 8'h02);
      chk("stall.option1", option, 3'd1);
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("stall%0d.grant", k), grant, 8'h02);
         chk($sformatf("stall%0d.valid", k), out_valid, 1'b1);
         chk($sformatf("stall%0d.beat_cnt", k), dut.beat_cnt, 8'd1);
         tick();
      end
      req = 8'h10; out_ready = 1'b1;
      #1;
      chk("abandon.valid", out_valid, 1'b0);
      tick();
      chk("abandon.grant", grant, 8'h10);
      chk("abandon.option", option, 3'd4);
      chk("abandon.beat_cnt", dut.beat_cnt, 8'd0);

      // Reset in the middle of a transfer by owner 5.
      req = 8'h30; req_last = 8'h10;
      #1;
      chk("midrst.valid4", out_valid, 1'b1);
      tick();
      chk("midrst.grant5", grant, 8'h20);
      req = 8'h20; req_last = 8'h00;
      tick();
      tick();
      chk("midrst.beat_cnt2", dut.beat_cnt, 8'd2);
      chk("midrst.still5", grant, 8'h20);
      rst = 1'b1; req = 8'h21;
      tick();
      chk("midrst.grant", grant, 8'h00);
      chk("midrst.option", option, 3'd0);
      chk("midrst.busy", busy, 1'b0);
      chk("midrst.valid", out_valid, 1'b0);
      chk("midrst.beat_cnt", dut.beat_cnt, 8'd0);
      rst = 1'b0;
      tick();
      chk("postrst.grant", grant, 8'h01);
      chk("postrst.option", option, 3'd0);
      chk("postrst.busy", busy, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
